i2s_receiver: RTL

I2S_RECEIVER -- requirements
Module: i2s_receiver

---
 rtl/codec_unit_pkg.sv | 7 +
 rtl/i2s_edge_sync.sv | 26 ++
 rtl/i2s_receiver.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/codec_unit_pkg.sv
// codec_unit_pkg: shared state type and sizing constants for the I2S receiver.
package codec_unit_pkg;
   localparam int SAMPLE_WIDTH_DEF = 24;
   localparam int BIT_CNT_W        = 6;
   localparam int STAT_CNT_W       = 16;
   typedef enum logic [2:0] {IDLE, SYNC, SKIP, SHIFT, PAD} rx_state_e;
endpackage

// File: rtl/i2s_edge_sync.sv
// i2s_edge_sync: multi-flop synchronizer followed by a one-cycle rise/fall detector.
module i2s_edge_sync #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);
   logic [STAGES-1:0] sync_q;
   logic              prev_q;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
         prev_q <= sync_q[STAGES-1];
      end
   end
   assign level_o = sync_q[STAGES-1];
   assign rise_o  = level_o & ~prev_q;
   assign fall_o  = ~level_o & prev_q;
endmodule

// File: rtl/i2s_receiver.sv
// i2s_receiver: I2S record receiver delivering {left,right} frames over valid/ready.
// Define I2S_RX_STATS_EN to add the frame_count/drop_count statistics outputs.
module i2s_receiver
   import codec_unit_pkg::*;
#(
   parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                      board_clk,
   input  logic                      reset,
   input  logic                      i2s_bclk,
   input  logic                      i2s_wclk,
   input  logic                      i2s_rdata,
   input  logic                      rx_en,
   input  logic                      clear_overrun,
   output logic [2*SAMPLE_WIDTH-1:0] data_out,
   output logic                      data_out_valid,
   input  logic                      data_out_ready,
   output logic                      overrun,
`ifdef I2S_RX_STATS_EN
   output logic [STAT_CNT_W-1:0]     frame_count,
   output logic [STAT_CNT_W-1:0]     drop_count,
`endif
   output logic                      frame_error
);
   logic bclk_lvl, bclk_rise, bclk_fall;
   logic wclk_lvl, wclk_rise, wclk_fall, wclk_chg;
   logic rdata_lvl, rdata_rise, rdata_fall;
   logic unused_edges;
   rx_state_e                 state_q, state_d;
   logic [BIT_CNT_W-1:0]      cnt_q, cnt_d;
   logic                      chan_q, chan_d;
   logic [SAMPLE_WIDTH-1:0]   shift_q, shift_d, left_q, left_d;
   logic [2*SAMPLE_WIDTH-1:0] data_q, data_d;
   logic                      valid_q, valid_d, overrun_q, overrun_d, ferr_q;
   logic                      done, err, load, ovf;

   i2s_edge_sync #(.STAGES(SYNC_STAGES)) u_bclk (
      .clk_i(board_clk), .rst_i(reset), .d_i(i2s_bclk),
      .level_o(bclk_lvl), .rise_o(bclk_rise), .fall_o(bclk_fall)
   );
   i2s_edge_sync #(.STAGES(SYNC_STAGES)) u_wclk (
      .clk_i(board_clk), .rst_i(reset), .d_i(i2s_wclk),
      .level_o(wclk_lvl), .rise_o(wclk_rise), .fall_o(wclk_fall)
   );
   i2s_edge_sync #(.STAGES(SYNC_STAGES)) u_rdata (
      .clk_i(board_clk), .rst_i(reset), .d_i(i2s_rdata),
      .level_o(rdata_lvl), .rise_o(rdata_rise), .fall_o(rdata_fall)
   );
   assign unused_edges = ^{bclk_lvl, bclk_fall, rdata_rise, rdata_fall};
   assign wclk_chg     = wclk_rise | wclk_fall;

   // wclk moves on the bclk falling edge, so its edge lands between bclk rises
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      chan_d  = chan_q;
      shift_d = shift_q;
      left_d  = left_q;
      done    = 1'b0;
      err     = 1'b0;
      if (!rx_en) state_d = IDLE;
      else begin
         case (state_q)
            IDLE: state_d = SYNC;
            SYNC: if (wclk_fall) begin
               state_d = SKIP;
               chan_d  = 1'b0;
            end
            SKIP: if (wclk_chg) begin
               state_d = SYNC;
               err     = 1'b1;
            end else if (bclk_rise) begin
               state_d = SHIFT;
               cnt_d   = '0;
            end
            SHIFT: if (wclk_chg) begin
               state_d = SYNC;
               err     = 1'b1;
            end else if (bclk_rise) begin
               shift_d = {shift_q[SAMPLE_WIDTH-2:0], rdata_lvl};
               cnt_d   = cnt_q + BIT_CNT_W'(1);
               if (cnt_q == BIT_CNT_W'(SAMPLE_WIDTH - 1)) begin
                  state_d = PAD;
                  left_d  = chan_q ? left_q : shift_d;
                  done    = chan_q;
               end
            end
            PAD: if (wclk_chg) begin
               state_d = SKIP;
               chan_d  = wclk_lvl;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      load      = done && (!valid_q || data_out_ready);
      ovf       = done && valid_q && !data_out_ready;
      data_d    = load ? {left_q, shift_d} : data_q;
      valid_d   = load || (valid_q && !data_out_ready);
      overrun_d = ovf || (overrun_q && !clear_overrun);
   end

   always_ff @(posedge board_clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         chan_q    <= 1'b0;
         shift_q   <= '0;
         left_q    <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         chan_q    <= chan_d;
         shift_q   <= shift_d;
         left_q    <= left_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
         ferr_q    <= err;
      end
   end

   assign data_out       = data_q;
   assign data_out_valid = valid_q;
   assign overrun        = overrun_q;
   assign frame_error    = ferr_q;

`ifdef I2S_RX_STATS_EN
   logic [STAT_CNT_W-1:0] frame_cnt_q, drop_cnt_q;
   always_ff @(posedge board_clk or posedge reset) begin
      if (reset) begin
         frame_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_q + STAT_CNT_W'(load);
         drop_cnt_q  <= drop_cnt_q + STAT_CNT_W'(ovf || err);
      end
   end
   assign frame_count = frame_cnt_q;
   assign drop_count  = drop_cnt_q;
`endif
endmodule
